muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the HI/LO resource.
- Arbitrates HI/LO writes between mthi/mtlo, the ALU product (mult/multu) and the iterative divider.
- Issues the divider start/cancel, counts multiply latency, and stalls F/D/E while a mult/div is in flight.
- Handles divide-by-zero, pipeline flush and a divider watchdog; drives the select of the hi_in/lo_in muxes.

Parameters:
- MUL_LAT, 1, multiply result latency in cycles (>=1); stall cycles = MUL_LAT-1.
- DIV_TIMEOUT, 40, cycles in DIV_WAIT without div_done_i before forced abort.
- CNT_W, 6, width of the latency/watchdog counter (must hold max(MUL_LAT, DIV_TIMEOUT)).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- div_req_i  in  1  div/divu present in EX
- mult_req_i  in  1  mult/multu present in EX
- mthi_i  in  1  mthi present in EX
- mtlo_i  in  1  mtlo present in EX
- signed_i  in  1  signed operation (hassign)
- divisor_zero_i  in  1  EX divisor operand == 0
- flush_i  in  1  squash EX instruction
- div_busy_i  in  1  divider busy
- div_done_i  in  1  divider result valid (1-cycle pulse)
- div_start_o  out  1  divider start pulse
- div_signed_o  out  1  signedness to divider
- div_cancel_o  out  1  divider abort pulse
- stall_o  out  1  to hazard unit: hold F/D/E
- hilo_we_o  out  2  {hi_we, lo_we}
- hilo_src_o  out  2  00 rs operand, 01 ALU product, 10 divider q/r
- busy_o  out  1  state != IDLE
- divzero_o  out  1  1-cycle flag: div by zero skipped
- timeout_o  out  1  1-cycle flag: watchdog abort

Behaviour:
- Reset: while rst low, state=IDLE, counter=0 and every output is 0. Reset mid-operation aborts with no HI/LO write; no cancel pulse is issued, because the divider shares the reset.
- States: IDLE, MUL_WAIT, DIV_WAIT. Outputs are combinational from the state and inputs.
- Request priority in IDLE when several are asserted: div > mult > mthi/mtlo; lower requests are ignored. Requests are ignored outside IDLE, since the instruction is held by the stall.
- flush_i in IDLE: all requests ignored; no write, start or stall.
- mthi/mtlo (IDLE): hilo_we_o={mthi_i,mtlo_i}, src=00 in the same cycle, no stall.
- mult, MUL_LAT==1 (IDLE): hilo_we_o=11, src=01 in the same cycle, no stall.
- mult, MUL_LAT>1:
  - Request cycle t: stall_o=1, counter<=MUL_LAT-2, go to MUL_WAIT.
  - MUL_WAIT with counter!=0: stall_o=1, counter decrements.
  - MUL_WAIT with counter==0: stall_o=0, hilo_we_o=11, src=01, go to IDLE.
  - Net effect: the write lands in cycle t+MUL_LAT-1.
- div with divisor_zero_i (IDLE): no start, no stall, no write; divzero_o=1 for one cycle.
- div with div_busy_i=1 (IDLE): stall_o=1, stay in IDLE, no start. Retry every cycle until busy is low.
- div otherwise (IDLE):
  - div_start_o=1 and stall_o=1 for one cycle.
  - div_signed_o=signed_i; the value is latched and held through DIV_WAIT.
  - counter<=0, go to DIV_WAIT.
- DIV_WAIT:
  - stall_o=1 and counter increments.
  - On div_done_i: stall_o=0, hilo_we_o=11, src=10, go to IDLE.
  - If counter==DIV_TIMEOUT-1 without done: div_cancel_o=1, timeout_o=1, stall_o=0, no write, go to IDLE.
- flush_i in MUL_WAIT or DIV_WAIT: stall_o=0, no write, go to IDLE.
  - In DIV_WAIT, div_cancel_o=1 for that cycle.
  - flush_i wins over a simultaneous div_done_i or timeout. timeout_o stays 0.
- div_done_i outside DIV_WAIT is ignored.
- hilo_we_o is 00 in every cycle not listed above.
- hilo_src_o defaults to 00 when no write occurs.

Test Plan:
- mtlo_i=1 in IDLE -> same cycle hilo_we_o=01, src=00, stall_o=0; mthi_i+mtlo_i -> hilo_we_o=11.
- MUL_LAT=3, mult_req_i at cycle t -> stall_o high at t and t+1; hilo_we_o=11, src=01 only at t+2; busy_o high at t+1 and t+2; IDLE at t+3.
- div_req_i, signed_i=1 at t, div_done_i at t+34 -> div_start_o pulse at t; stall_o high t..t+33; write 11/src 10 at t+34; div_signed_o=1 throughout.
- div_req_i with divisor_zero_i=1 -> divzero_o pulse, no start, no stall, hilo_we_o=00; then div with div_busy_i=1 for 3 cycles -> stall for those 3 cycles with no start, start on the 4th.
- div in flight, flush_i and div_done_i together at t+10 -> div_cancel_o=1, hilo_we_o=00, stall_o=0, IDLE at t+11.
- DIV_TIMEOUT=40, divider never done -> timeout_o and div_cancel_o at the 40th DIV_WAIT cycle with no write; rst low mid-DIV_WAIT -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for the HI/LO register pair.
// Arbitrates HI/LO writes between mthi/mtlo, the multiplier product and the
// iterative divider. It also starts and cancels the divider, counts multiply
// latency, runs a divider watchdog and stalls F/D/E while an operation is in
// flight.
//
// Handshake with the divider: div_start_o is a one-cycle pulse. It is issued
// only when div_busy_i is low. The controller then waits for the one-cycle
// div_done_i pulse. div_cancel_o is a one-cycle abort pulse, raised on a
// flush or on a watchdog expiry while waiting.
//
// All outputs are forced to 0 while rst is low. The divider shares this
// reset, so no cancel pulse is needed when a reset aborts an operation.
module muldiv_ctrl #(
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_req_i,
  input  logic       mult_req_i,
  input  logic       mthi_i,
  input  logic       mtlo_i,
  input  logic       signed_i,
  input  logic       divisor_zero_i,
  input  logic       flush_i,
  input  logic       div_busy_i,
  input  logic       div_done_i,
  output logic       div_start_o,
  output logic       div_signed_o,
  output logic       div_cancel_o,
  output logic       stall_o,
  output logic [1:0] hilo_we_o,
  output logic [1:0] hilo_src_o,
  output logic       busy_o,
  output logic       divzero_o,
  output logic       timeout_o,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] SRC_RS  = 2'b00;
  localparam logic [1:0] SRC_MUL = 2'b01;
  localparam logic [1:0] SRC_DIV = 2'b10;

  // MUL_WAIT starts at MUL_LAT-2 so that the write lands in cycle t+MUL_LAT-1.
  localparam int              MUL_INIT   = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] MUL_INIT_C = CNT_W'(MUL_INIT);
  localparam logic [CNT_W-1:0] DIV_LAST_C = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;

  logic       start_c, sgn_c, cancel_c, stall_c, dz_c, to_c;
  logic [1:0] we_c, src_c;

  // State, latency/watchdog counter and latched divider signedness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
    end
  end

  // Next-state logic and combinational outputs. Requests are only looked at
  // in IDLE; while an operation is in flight the instruction is held by the stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    start_c  = 1'b0;
    sgn_c    = 1'b0;
    cancel_c = 1'b0;
    stall_c  = 1'b0;
    we_c     = 2'b00;
    src_c    = SRC_RS;
    dz_c     = 1'b0;
    to_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (div_req_i) begin
            if (divisor_zero_i) begin
              // Skip the divide entirely; HI/LO stay unchanged.
              dz_c = 1'b1;
            end else if (div_busy_i) begin
              // Hold the instruction and retry next cycle.
              stall_c = 1'b1;
            end else begin
              start_c  = 1'b1;
              stall_c  = 1'b1;
              sgn_c    = signed_i;
              signed_d = signed_i;
              cnt_d    = '0;
              state_d  = DIV_WAIT;
            end
          end else if (mult_req_i) begin
            if (MUL_LAT == 1) begin
              we_c  = 2'b11;
              src_c = SRC_MUL;
            end else begin
              stall_c = 1'b1;
              cnt_d   = MUL_INIT_C;
              state_d = MUL_WAIT;
            end
          end else if (mthi_i || mtlo_i) begin
            we_c  = {mthi_i, mtlo_i};
            src_c = SRC_RS;
          end
        end
      end
      MUL_WAIT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - ONE_C;
        end else begin
          we_c    = 2'b11;
          src_c   = SRC_MUL;
          state_d = IDLE;
        end
      end
      DIV_WAIT: begin
        sgn_c = signed_q;
        if (flush_i) begin
          // A flush beats a simultaneous done or watchdog expiry.
          cancel_c = 1'b1;
          state_d  = IDLE;
        end else if (div_done_i) begin
          we_c    = 2'b11;
          src_c   = SRC_DIV;
          state_d = IDLE;
        end else if (cnt_q == DIV_LAST_C) begin
          cancel_c = 1'b1;
          to_c     = 1'b1;
          state_d  = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are gated by reset so nothing leaks out while rst is low.
  assign div_start_o  = rst & start_c;
  assign div_signed_o = rst & sgn_c;
  assign div_cancel_o = rst & cancel_c;
  assign stall_o      = rst & stall_c;
  assign hilo_we_o    = {2{rst}} & we_c;
  assign hilo_src_o   = {2{rst}} & src_c;
  assign busy_o       = rst & (state_q != IDLE);
  assign divzero_o    = rst & dz_c;
  assign timeout_o    = rst & to_c;
  assign state_dbg_o  = {2{rst}} & state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl. u_dut uses MUL_LAT=3 and DIV_TIMEOUT=40, and
// u_dut1 uses MUL_LAT=1. Both are driven by the same inputs. Single-cycle
// IDLE behaviour is table-driven. Multi-cycle mult/div/flush/timeout/reset
// cases are hand-written sequences.
module tb_muldiv_ctrl;

  typedef struct packed {
    logic div, mult, mthi, mtlo, sgn, dzero, flush, dbusy, ddone;
  } in_t;

  typedef struct packed {
    logic       start, sgn, cancel, stall;
    logic [1:0] we, src;
    logic       busy, dz, to;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic div_req, mult_req, mthi, mtlo, signed_v, dzero, flush, dbusy, ddone;

  logic       start0, sgn0, cancel0, stall0, busy0, dz0, to0;
  logic [1:0] we0, src0, st0;
  logic       start1, sgn1, cancel1, stall1, busy1, dz1, to1;
  logic [1:0] we1, src1, st1;

  out_t act0, act1;
  assign act0 = {start0, sgn0, cancel0, stall0, we0, src0, busy0, dz0, to0};
  assign act1 = {start1, sgn1, cancel1, stall1, we1, src1, busy1, dz1, to1};

  muldiv_ctrl #(.MUL_LAT(3), .DIV_TIMEOUT(40), .CNT_W(6)) u_dut (
    .clk(clk), .rst(rst),
    .div_req_i(div_req), .mult_req_i(mult_req), .mthi_i(mthi), .mtlo_i(mtlo),
    .signed_i(signed_v), .divisor_zero_i(dzero), .flush_i(flush),
    .div_busy_i(dbusy), .div_done_i(ddone),
    .div_start_o(start0), .div_signed_o(sgn0), .div_cancel_o(cancel0),
    .stall_o(stall0), .hilo_we_o(we0), .hilo_src_o(src0), .busy_o(busy0),
    .divzero_o(dz0), .timeout_o(to0), .state_dbg_o(st0)
  );

  muldiv_ctrl #(.MUL_LAT(1), .DIV_TIMEOUT(40), .CNT_W(6)) u_dut1 (
    .clk(clk), .rst(rst),
    .div_req_i(div_req), .mult_req_i(mult_req), .mthi_i(mthi), .mtlo_i(mtlo),
    .signed_i(signed_v), .divisor_zero_i(dzero), .flush_i(flush),
    .div_busy_i(dbusy), .div_done_i(ddone),
    .div_start_o(start1), .div_signed_o(sgn1), .div_cancel_o(cancel1),
    .stall_o(stall1), .hilo_we_o(we1), .hilo_src_o(src1), .busy_o(busy1),
    .divzero_o(dz1), .timeout_o(to1), .state_dbg_o(st1)
  );

  int total = 0;
  int bad   = 0;

  // Driver helpers
  function automatic in_t mi(input logic div, mult, hi, lo, sgn, dz, fl, bsy, dn);
    return {div, mult, hi, lo, sgn, dz, fl, bsy, dn};
  endfunction

  function automatic out_t mo(input logic start, sgn, cancel, stall,
                              input logic [1:0] we, src,
                              input logic busy, dz, to);
    return {start, sgn, cancel, stall, we, src, busy, dz, to};
  endfunction

  task automatic set_in(input in_t v);
    {div_req, mult_req, mthi, mtlo, signed_v, dzero, flush, dbusy, ddone} = v;
  endtask

  // Scoreboard
  task automatic check_out(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got start,sgn,cancel,stall,we,src,busy,dz,to=%b_%b_%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b_%b_%b",
               name, act.start, act.sgn, act.cancel, act.stall, act.we, act.src, act.busy, act.dz, act.to,
               exp.start, exp.sgn, exp.cancel, exp.stall, exp.we, exp.src, exp.busy, exp.dz, exp.to);
    end
  endtask

  task automatic check_st(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: state got %0d want %0d", name, act, exp);
    end
  endtask

  localparam out_t ZO = '0;
  localparam in_t  ZI = '0;

  vec_t vecs[12];

  initial begin
    // Single-cycle IDLE vectors; expectations hold for both instances.
    //                        div mul hi lo sgn dz fl bsy dn
    vecs[0]  = '{"mtlo",       mi(0,0,0,1,0,0,0,0,0), mo(0,0,0,0,2'b01,2'b00,0,0,0)};
    vecs[1]  = '{"mthi",       mi(0,0,1,0,0,0,0,0,0), mo(0,0,0,0,2'b10,2'b00,0,0,0)};
    vecs[2]  = '{"mthi_mtlo",  mi(0,0,1,1,0,0,0,0,0), mo(0,0,0,0,2'b11,2'b00,0,0,0)};
    vecs[3]  = '{"flush_mtlo", mi(0,0,0,1,0,0,1,0,0), ZO};
    vecs[4]  = '{"flush_div",  mi(1,0,0,0,1,0,1,0,0), ZO};
    vecs[5]  = '{"divzero",    mi(1,0,0,0,0,1,0,0,0), mo(0,0,0,0,2'b00,2'b00,0,1,0)};
    vecs[6]  = '{"dz_over_mul",mi(1,1,1,0,0,1,0,0,0), mo(0,0,0,0,2'b00,2'b00,0,1,0)};
    vecs[7]  = '{"div_busy",   mi(1,0,0,0,0,0,0,1,0), mo(0,0,0,1,2'b00,2'b00,0,0,0)};
    vecs[8]  = '{"busy_over_hi",mi(1,0,1,0,0,0,0,1,0), mo(0,0,0,1,2'b00,2'b00,0,0,0)};
    vecs[9]  = '{"done_idle",  mi(0,0,0,0,0,0,0,0,1), ZO};
    vecs[10] = '{"idle",       ZI, ZO};
    vecs[11] = '{"dz_signed",  mi(1,0,0,0,1,1,0,0,0), mo(0,0,0,0,2'b00,2'b00,0,1,0)};

    // Reset: requests asserted while rst is low must produce nothing.
    set_in(mi(1,0,1,1,1,0,0,0,0));
    repeat (2) @(negedge clk);
    #1 check_out("reset_hold", act0, ZO);
    check_st("reset_state", st0, 2'd0);
    @(negedge clk);
    set_in(ZI);
    rst = 1'b1;
    #1 check_out("after_reset", act0, ZO);

    // Table-driven IDLE vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      set_in(vecs[i].in);
      #1;
      check_out(vecs[i].name, act0, vecs[i].exp);
      check_out({vecs[i].name, "_lat1"}, act1, vecs[i].exp);
      @(posedge clk);
      #1 check_st({vecs[i].name, "_post"}, st0, 2'd0);
    end

    // mult: MUL_LAT=3 on u_dut, MUL_LAT=1 on u_dut1. mult_req stays high
    // while held to show it is ignored outside IDLE.
    @(negedge clk);
    set_in(mi(0,1,0,0,0,0,0,0,0));
    #1 check_out("mul_t", act0, mo(0,0,0,1,2'b00,2'b00,0,0,0));
    check_out("mul1_t", act1, mo(0,0,0,0,2'b11,2'b01,0,0,0));
    @(negedge clk);
    #1 check_out("mul_t1", act0, mo(0,0,0,1,2'b00,2'b00,1,0,0));
    @(negedge clk);
    #1 check_out("mul_t2", act0, mo(0,0,0,0,2'b11,2'b01,1,0,0));
    @(negedge clk);
    set_in(ZI);
    #1 check_out("mul_t3", act0, ZO);
    check_st("mul_t3_state", st0, 2'd0);

    // Signed divide, done at t+34; signed_i changes mid-flight to test the latch.
    @(negedge clk);
    set_in(mi(1,0,0,0,1,0,0,0,0));
    #1 check_out("div_t", act0, mo(1,1,0,1,2'b00,2'b00,0,0,0));
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      signed_v = (k > 5) ? 1'b0 : 1'b1;
      #1 check_out($sformatf("div_wait_%0d", k), act0, mo(0,1,0,1,2'b00,2'b00,1,0,0));
    end
    @(negedge clk);
    ddone = 1'b1;
    #1 check_out("div_done", act0, mo(0,1,0,0,2'b11,2'b10,1,0,0));
    @(negedge clk);
    set_in(ZI);
    #1 check_out("div_after", act0, ZO);
    check_st("div_after_state", st0, 2'd0);

    // Divider busy for 3 cycles, start on the 4th, then flush+done at t+10.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(mi(1,0,0,0,0,0,0,1,0));
      #1 check_out($sformatf("busy_retry_%0d", k), act0, mo(0,0,0,1,2'b00,2'b00,0,0,0));
    end
    @(negedge clk);
    dbusy = 1'b0;
    #1 check_out("busy_start", act0, mo(1,0,0,1,2'b00,2'b00,0,0,0));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1 check_out($sformatf("fl_wait_%0d", k), act0, mo(0,0,0,1,2'b00,2'b00,1,0,0));
    end
    @(negedge clk);
    flush = 1'b1;
    ddone = 1'b1;
    #1 check_out("flush_done", act0, mo(0,0,1,0,2'b00,2'b00,1,0,0));
    @(negedge clk);
    set_in(ZI);
    #1 check_out("flush_after", act0, ZO);
    check_st("flush_after_state", st0, 2'd0);

    // Watchdog: no done; abort on the 40th DIV_WAIT cycle.
    @(negedge clk);
    set_in(mi(1,0,0,0,0,0,0,0,0));
    #1 check_out("to_start", act0, mo(1,0,0,1,2'b00,2'b00,0,0,0));
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      #1 check_out($sformatf("to_wait_%0d", k), act0, mo(0,0,0,1,2'b00,2'b00,1,0,0));
    end
    @(negedge clk);
    #1 check_out("to_fire", act0, mo(0,0,1,0,2'b00,2'b00,1,0,1));
    @(negedge clk);
    set_in(ZI);
    #1 check_out("to_after", act0, ZO);
    check_st("to_after_state", st0, 2'd0);

    // Reset mid DIV_WAIT: outputs drop immediately, back in IDLE.
    @(negedge clk);
    set_in(mi(1,0,0,0,1,0,0,0,0));
    #1 check_out("rst_start", act0, mo(1,1,0,1,2'b00,2'b00,0,0,0));
    repeat (5) @(negedge clk);
    set_in(mi(1,0,1,0,1,0,0,0,1));
    rst = 1'b0;
    #1 check_out("rst_mid", act0, ZO);
    check_st("rst_mid_state", st0, 2'd0);
    @(negedge clk);
    set_in(ZI);
    rst = 1'b1;
    #1 check_out("rst_release", act0, ZO);
    @(negedge clk);
    set_in(mi(0,0,0,1,0,0,0,0,0));
    #1 check_out("rst_then_mtlo", act0, mo(0,0,0,0,2'b01,2'b00,0,0,0));
    @(negedge clk);
    set_in(ZI);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
